// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: two-port arbiter in front of a single-ported 32-bit data memory.
// Port 0 serves CPU loads/stores and port 1 serves DMA/debug. Each accepted request
// takes one ACCESS cycle at the memory and one RESP cycle back to the requester.
// Optional feature: define MEM_ARB_RR_EN for round-robin arbitration. When it is
// undefined, arbitration is fixed-priority with port 0 winning ties.
module data_mem_arbiter #(
    parameter int unsigned MEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst,

    // Port 0: CPU load/store
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_gnt,
    output logic        p0_rvalid,
    output logic [31:0] p0_rdata,
    output logic        p0_err,

    // Port 1: DMA/debug
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_gnt,
    output logic        p1_rvalid,
    output logic [31:0] p1_rdata,
    output logic        p1_err,

    // Memory side
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    // FSM encoding
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    // First byte address past the end of the memory; 33 bits so it cannot wrap.
    localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) << 2;

    // State
    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic        r_run;

    // Captured command
    logic        r_cmd_port;
    logic        r_cmd_we;
    logic [31:0] r_cmd_addr;
    logic [31:0] r_cmd_wdata;
    logic        r_cmd_err;

    // Per-port response registers
    logic [31:0] r_p0_rdata;
    logic [31:0] r_p1_rdata;
    logic        r_p0_err;
    logic        r_p1_err;

    // Decode and arbitration wires
    logic        w_in_access;
    logic        w_in_resp;
    logic        w_arb_en;
    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_any_gnt;
    logic        w_sel_we;
    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_wdata;
    logic        w_sel_err;
    logic [31:0] w_resp_data;

    assign w_in_access = (r_state == S_ACCESS);
    assign w_in_resp   = (r_state == S_RESP);

    // Arbitration is only open in IDLE and RESP, and only once the first
    // clock edge after reset release has been seen.
    assign w_arb_en = r_run & ((r_state == S_IDLE) | (r_state == S_RESP));

    // Run flag: blocks grants until the first posedge after reset is released
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

`ifdef MEM_ARB_RR_EN
    // 0: port 0 wins a tie, 1: port 1 wins a tie
    logic r_prio;

    // Round-robin grant: the pointer only matters when both ports request
    always_comb begin
        w_gnt0 = w_arb_en & p0_req & (~p1_req | ~r_prio);
        w_gnt1 = w_arb_en & p1_req & (~p0_req |  r_prio);
    end

    // Pointer moves to the port that was not granted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prio <= 1'b0;
        end else if (w_gnt0) begin
            r_prio <= 1'b1;
        end else if (w_gnt1) begin
            r_prio <= 1'b0;
        end
    end
`else
    // Fixed-priority grant: port 0 always wins a tie
    always_comb begin
        w_gnt0 = w_arb_en & p0_req;
        w_gnt1 = w_arb_en & p1_req & ~p0_req;
    end
`endif

    assign w_any_gnt = w_gnt0 | w_gnt1;

    // Select the winning port's command and classify it
    always_comb begin
        if (w_gnt1) begin
            w_sel_we    = p1_we;
            w_sel_addr  = p1_addr;
            w_sel_wdata = p1_wdata;
        end else begin
            w_sel_we    = p0_we;
            w_sel_addr  = p0_addr;
            w_sel_wdata = p0_wdata;
        end
        w_sel_err = ({1'b0, w_sel_addr} >= ADDR_LIMIT) | (w_sel_addr[1:0] != 2'b00);
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = S_IDLE;
        case (r_state)
            S_IDLE:   w_state_nxt = w_any_gnt ? S_ACCESS : S_IDLE;
            S_ACCESS: w_state_nxt = S_RESP;
            S_RESP:   w_state_nxt = w_any_gnt ? S_ACCESS : S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // State register; async reset aborts any access in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Command register: loaded on every grant
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cmd_port  <= 1'b0;
            r_cmd_we    <= 1'b0;
            r_cmd_addr  <= '0;
            r_cmd_wdata <= '0;
            r_cmd_err   <= 1'b0;
        end else if (w_any_gnt) begin
            r_cmd_port  <= w_gnt1;
            r_cmd_we    <= w_sel_we;
            r_cmd_addr  <= w_sel_addr;
            r_cmd_wdata <= w_sel_wdata;
            r_cmd_err   <= w_sel_err;
        end
    end

    // Writes and faulting accesses return zero instead of memory data
    assign w_resp_data = (r_cmd_we | r_cmd_err) ? 32'd0 : mem_rdata;

    // Response registers: loaded at the end of ACCESS for the owning port, held otherwise
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_p0_rdata <= '0;
            r_p0_err   <= 1'b0;
            r_p1_rdata <= '0;
            r_p1_err   <= 1'b0;
        end else if (w_in_access) begin
            if (r_cmd_port) begin
                r_p1_rdata <= w_resp_data;
                r_p1_err   <= r_cmd_err;
            end else begin
                r_p0_rdata <= w_resp_data;
                r_p0_err   <= r_cmd_err;
            end
        end
    end

    // Memory drive: only the ACCESS cycle presents a command; faulting writes are suppressed
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_in_access) begin
            mem_we    = r_cmd_we & ~r_cmd_err;
            mem_addr  = r_cmd_addr;
            mem_wdata = r_cmd_wdata;
        end
    end

    // Port outputs
    always_comb begin
        p0_gnt    = w_gnt0;
        p1_gnt    = w_gnt1;
        p0_rvalid = w_in_resp & ~r_cmd_port;
        p1_rvalid = w_in_resp &  r_cmd_port;
        p0_rdata  = r_p0_rdata;
        p1_rdata  = r_p1_rdata;
        p0_err    = r_p0_err;
        p1_err    = r_p1_err;
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: table of single-port transactions plus
// hand-written sequences for contention, back-to-back reads and reset abort.
module tb_data_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        p0_req, p0_we, p0_gnt, p0_rvalid, p0_err;
    logic [31:0] p0_addr, p0_wdata, p0_rdata;
    logic        p1_req, p1_we, p1_gnt, p1_rvalid, p1_err;
    logic [31:0] p1_addr, p1_wdata, p1_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;
    int we_count = 0;

    logic [31:0] mem [0:63];

    data_mem_arbiter #(.MEM_WORDS(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .p0_req    (p0_req),
        .p0_we     (p0_we),
        .p0_addr   (p0_addr),
        .p0_wdata  (p0_wdata),
        .p0_gnt    (p0_gnt),
        .p0_rvalid (p0_rvalid),
        .p0_rdata  (p0_rdata),
        .p0_err    (p0_err),
        .p1_req    (p1_req),
        .p1_we     (p1_we),
        .p1_addr   (p1_addr),
        .p1_wdata  (p1_wdata),
        .p1_gnt    (p1_gnt),
        .p1_rvalid (p1_rvalid),
        .p1_rdata  (p1_rdata),
        .p1_err    (p1_err),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: combinational read, synchronous write
    assign mem_rdata = mem[mem_addr[7:2]];
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr[7:2]] <= mem_wdata;
            we_count <= we_count + 1;
        end
    end

    typedef struct {
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic port, input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (!port) begin
            p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata;
        end else begin
            p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata;
        end
    endtask

    function automatic logic gnt_of(input logic port);
        return port ? p1_gnt : p0_gnt;
    endfunction

    function automatic logic rvalid_of(input logic port);
        return port ? p1_rvalid : p0_rvalid;
    endfunction

    function automatic logic [31:0] rdata_of(input logic port);
        return port ? p1_rdata : p0_rdata;
    endfunction

    function automatic logic err_of(input logic port);
        return port ? p1_err : p0_err;
    endfunction

    // One complete single-port transaction with cycle-exact checks
    task automatic do_txn(input string tag, input logic port, input logic we,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic exp_err, input logic [31:0] exp_rdata);
        int  wait_cyc;
        int  we_before;
        logic got;
        logic exp_we;
        exp_we = we & ~exp_err;
        @(posedge clk); #1;
        drive(port, 1'b1, we, addr, wdata);
        wait_cyc = 0;
        got = 1'b0;
        while (!got && wait_cyc < 20) begin
            @(negedge clk);
            if (gnt_of(port)) got = 1'b1;
            else wait_cyc++;
        end
        check({tag, "_gnt"}, {31'd0, got}, 32'd1);
        if (!got) begin
            drive(port, 1'b0, 1'b0, 32'd0, 32'd0);
            return;
        end
        check({tag, "_other_gnt"}, {31'd0, gnt_of(~port)}, 32'd0);
        @(posedge clk); #1;
        drive(port, 1'b0, 1'b0, 32'd0, 32'd0);
        we_before = we_count;
        @(negedge clk);
        check({tag, "_acc_we"}, {31'd0, mem_we}, {31'd0, exp_we});
        check({tag, "_acc_addr"}, mem_addr, addr);
        check({tag, "_acc_wdata"}, mem_wdata, wdata);
        check({tag, "_acc_rvalid"}, {31'd0, rvalid_of(port)}, 32'd0);
        @(negedge clk);
        check({tag, "_rvalid"}, {31'd0, rvalid_of(port)}, 32'd1);
        check({tag, "_other_rvalid"}, {31'd0, rvalid_of(~port)}, 32'd0);
        check({tag, "_rdata"}, rdata_of(port), exp_rdata);
        check({tag, "_err"}, {31'd0, err_of(port)}, {31'd0, exp_err});
        check({tag, "_resp_mem"}, {mem_we, mem_addr[30:0]} | mem_wdata, 32'd0);
        check({tag, "_we_pulses"}, we_count - we_before, exp_we ? 32'd1 : 32'd0);
        @(negedge clk);
        check({tag, "_rvalid_drop"}, {31'd0, rvalid_of(port)}, 32'd0);
        check({tag, "_rdata_hold"}, rdata_of(port), exp_rdata);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    initial begin
        logic [3:0]  exp_order;
        logic [3:0]  order;
        int          gcyc [4];
        int          n;
        logic        g [10];
        logic        v [10];
        logic [31:0] d [10];
        int          we_before;
        logic        got;

        // port, we, addr, wdata, exp_err, exp_rdata
        vecs[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 1'b1, 32'h0000_0000, 32'h1234_5678, 1'b0, 32'h0};
        vecs[3]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h1234_5678};
        vecs[4]  = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,         1'b1, 32'h0};
        vecs[5]  = '{1'b1, 1'b1, 32'h0000_0006, 32'hCAFE_F00D, 1'b1, 32'h0};
        vecs[6]  = '{1'b0, 1'b1, 32'h0000_00FC, 32'hA5A5_5A5A, 1'b0, 32'h0};
        vecs[7]  = '{1'b1, 1'b0, 32'h0000_00FC, 32'h0,         1'b0, 32'hA5A5_5A5A};
        vecs[8]  = '{1'b0, 1'b0, 32'h0000_00FF, 32'h0,         1'b1, 32'h0};
        vecs[9]  = '{1'b0, 1'b1, 32'h0000_0100, 32'hBAD0_BAD0, 1'b1, 32'h0};
        vecs[10] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h1234_5678};
        vecs[11] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};

        // Reset state with both ports requesting
        rst = 1'b0;
        drive(1'b0, 1'b1, 1'b1, 32'h10, 32'h5555_5555);
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
        #12;
        check("rst_gnt", {30'd0, p1_gnt, p0_gnt}, 32'd0);
        check("rst_rvalid", {30'd0, p1_rvalid, p0_rvalid}, 32'd0);
        check("rst_err", {30'd0, p1_err, p0_err}, 32'd0);
        check("rst_p0_rdata", p0_rdata, 32'd0);
        check("rst_p1_rdata", p1_rdata, 32'd0);
        check("rst_mem", {31'd0, mem_we} | mem_addr | mem_wdata, 32'd0);
        @(posedge clk); #1 rst = 1'b1;
        #1;
        check("rel_gnt", {30'd0, p1_gnt, p0_gnt}, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);

        // Table of single-port transactions
        for (int i = 0; i < 12; i++) begin
            do_txn($sformatf("v%0d", i), vecs[i].port, vecs[i].we, vecs[i].addr,
                   vecs[i].wdata, vecs[i].exp_err, vecs[i].exp_rdata);
        end

        // Contention: both ports held for four grants, starting from a fresh pointer
        do_reset();
`ifdef MEM_ARB_RR_EN
        exp_order = 4'b1010;
`else
        exp_order = 4'b0000;
`endif
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b0, 32'h10, 32'd0);
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'd0);
        n = 0;
        order = 4'b0000;
        for (int c = 0; c < 20 && n < 4; c++) begin
            @(negedge clk);
            check("arb_onehot", {31'd0, p0_gnt & p1_gnt}, 32'd0);
            if (p0_gnt || p1_gnt) begin
                order[n] = p1_gnt;
                gcyc[n] = c;
                n++;
            end
        end
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        check("arb_count", n, 32'd4);
        check("arb_order", {28'd0, order}, {28'd0, exp_order});
        for (int k = 1; k < n; k++) begin
            check($sformatf("arb_spacing%0d", k), gcyc[k] - gcyc[k-1], 32'd2);
        end
        repeat (3) @(negedge clk);

        // Continuous port 0 reads: grant every 2nd cycle, rvalid 2 cycles behind
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b0, 32'h10, 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            g[i] = p0_gnt;
            v[i] = p0_rvalid;
            d[i] = p0_rdata;
        end
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("b2b_gnt%0d", i), {31'd0, g[i]}, (i % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("b2b_rvalid%0d", i), {31'd0, v[i]},
                  (i >= 2 && i % 2 == 0) ? 32'd1 : 32'd0);
            if (i >= 2 && i % 2 == 0) check($sformatf("b2b_rdata%0d", i), d[i], 32'hDEAD_BEEF);
        end
        repeat (2) @(negedge clk);

        // Reset in the ACCESS cycle of a port 0 write aborts it
        do_txn("pre", 1'b0, 1'b1, 32'h30, 32'h1111_1111, 1'b0, 32'h0);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b1, 32'h30, 32'h2222_2222);
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            got = p0_gnt;
        end
        check("abort_gnt", {31'd0, got}, 32'd1);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        we_before = we_count;
        check("abort_we_before", {31'd0, mem_we}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("abort_we_drop", {31'd0, mem_we}, 32'd0);
        check("abort_addr_drop", mem_addr, 32'd0);
        @(posedge clk); #1 rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("abort_no_rvalid%0d", c), {31'd0, p0_rvalid}, 32'd0);
        end
        check("abort_no_write", we_count - we_before, 32'd0);
        do_txn("post", 1'b0, 1'b0, 32'h30, 32'd0, 1'b0, 32'h1111_1111);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter MEM_WORDS, default 64, number of 32-bit words in the attached data memory; legal byte addresses are 0 .. MEM_WORDS*4-1.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 p0_req/p1_req  input  1  port request (port 0 = CPU load/store, port 1 = DMA/debug).
REQ-005 p0_we/p1_we  input  1  request is a write when 1, read when 0.
REQ-006 p0_addr/p1_addr  input  32  byte address.
REQ-007 p0_wdata/p1_wdata  input  32  write data.
REQ-008 p0_gnt/p1_gnt  output  1  one-cycle pulse; request accepted this cycle.
REQ-009 p0_rvalid/p1_rvalid  output  1  one-cycle pulse; access complete, rdata valid.
REQ-010 p0_rdata/p1_rdata  output  32  read data; also valid on a write completion, 0.
REQ-011 p0_err/p1_err  output  1  qualifies rvalid; access was out of range or misaligned.
REQ-012 mem_we  output  1  write strobe to the memory.
REQ-013 mem_addr/mem_wdata  output  32  address and data to the memory.
REQ-014 mem_rdata  input  32  combinational read data from the memory.

Function
REQ-015 FSM states IDLE, ACCESS, RESP; ACCESS always follows a grant, RESP always follows ACCESS.
REQ-016 Arbitration is evaluated in IDLE and RESP; if any req is high, exactly one gnt pulses, the winner's we/addr/wdata are captured into a command register, and the next state is ACCESS; otherwise the next state is IDLE.
REQ-017 A requester holds req and its command stable until its gnt; req may drop in the gnt cycle.
REQ-018 In ACCESS, mem_addr/mem_wdata drive the captured command and mem_we = captured we AND NOT err; mem_rdata is registered at the end of ACCESS.
REQ-019 In RESP, the granted port's rvalid is 1 for exactly one cycle with rdata = registered mem_rdata (read) or 0 (write); the other port's rvalid stays 0.
REQ-020 Latency: gnt in cycle N gives ACCESS in N+1 and rvalid in N+2; back-to-back grants give one access every 2 cycles.
REQ-021 err = addr >= MEM_WORDS*4 OR addr[1:0] != 0; on err, mem_we stays 0, rdata = 0, err pulses with rvalid.
REQ-022 Outside ACCESS, mem_we = 0 and mem_addr = mem_wdata = 0.
REQ-023 Port rdata/err hold their last value between rvalid pulses.
REQ-024 Address 0 is legal and is passed through unchanged; read-as-zero behaviour is the memory's responsibility.

Reset
REQ-025 rst low immediately forces state IDLE, all gnt/rvalid/err/mem_we = 0, rdata/mem_addr/mem_wdata/command register = 0, priority pointer = port 0.
REQ-026 Reset during ACCESS or RESP aborts the access: no write is issued after rst falls, and no rvalid is produced for it.
REQ-027 The first grant occurs no earlier than the first posedge after rst rises.

Configuration
REQ-028 When MEM_ARB_RR_EN is defined, arbitration is round-robin: on simultaneous requests the port indicated by the priority pointer wins, and after each grant the pointer moves to the non-granted port.
REQ-029 When MEM_ARB_RR_EN is not defined, arbitration is fixed-priority: port 0 always wins simultaneous requests, and the priority pointer is not implemented.

Verification
REQ-030 Port 0 write addr 0x10 data 0xDEADBEEF, then read 0x10 -> mem_we pulses once in ACCESS; the read's p0_rvalid carries 0xDEADBEEF two cycles after its gnt.
REQ-031 p0_req and p1_req held high together for 4 grants -> with MEM_ARB_RR_EN the gnt order is 0,1,0,1; without it the order is 0,0,0,0 and p1 receives no gnt.
REQ-032 p1 read addr 0x100 with MEM_WORDS=64, then p1 write addr 0x6 -> each gives p1_rvalid=1, p1_err=1, p1_rdata=0, and mem_we stays 0.
REQ-033 rst pulled low in the ACCESS cycle of a port 0 write -> mem_we drops immediately, the memory word is unchanged, and no p0_rvalid is produced.
REQ-034 Continuous p0 reads -> gnt pulses every 2nd cycle, with rvalid following each gnt by exactly 2 cycles.
